// File: rtl/spi_frame_rx.sv
// SPI slave receiver: assembles NUM_WORDS words of WORD_W bits into one frame,
// holds it behind a valid/ack handshake and echoes the last word on MISO.
module spi_frame_rx #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 4,
  parameter int LSB_FIRST = 1,
  parameter int CNT_W     = 8
) (
  input  logic                        sclk,
  input  logic                        rst,
  input  logic                        cs,
  input  logic                        mosi,
  output logic                        miso,
  input  logic                        frame_ack,
  input  logic                        clr_status,
  output logic [NUM_WORDS*WORD_W-1:0] frame_data,
  output logic                        frame_valid,
  output logic                        overrun,
  output logic                        frame_err,
  output logic [CNT_W-1:0]            frame_cnt
);

  localparam int BIT_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int IDX_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int FRAME_W = NUM_WORDS * WORD_W;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

  logic [WORD_W-1:0]  shift_q, shift_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic [WORD_W-1:0]  stage_q [NUM_WORDS];
  logic [WORD_W-1:0]  stage_d [NUM_WORDS];
  logic [WORD_W-1:0]  echo_q, echo_d;
  logic               miso_q, miso_d;
  logic [FRAME_W-1:0] frame_data_q, frame_data_d;
  logic               frame_valid_q, frame_valid_d;
  logic               overrun_q, overrun_d;
  logic               frame_err_q, frame_err_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic [WORD_W-1:0]  word_asm;
  logic [FRAME_W-1:0] frame_full;
  logic [BIT_W-1:0]   miso_sel;
  logic               word_done;
  logic               frame_done;
  logic               ovr_set;
  logic               err_set;

  // Shifted word including the bit sampled on this edge.
  always_comb begin
    if (LSB_FIRST != 0) begin
      word_asm = {mosi, shift_q[WORD_W-1:1]};
      miso_sel = bit_cnt_q;
    end else begin
      word_asm = {shift_q[WORD_W-2:0], mosi};
      miso_sel = BIT_LAST - bit_cnt_q;
    end
  end

  assign word_done  = !cs && (bit_cnt_q == BIT_LAST);
  assign frame_done = word_done && (word_idx_q == IDX_LAST);

  // The final word bypasses the staging slot so the frame is complete on its last edge.
  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_frame
    if (gi == NUM_WORDS - 1) begin : g_last
      assign frame_full[gi*WORD_W +: WORD_W] = word_asm;
    end else begin : g_stage
      assign frame_full[gi*WORD_W +: WORD_W] = stage_q[gi];
    end
  end

  always_comb begin
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    word_idx_d    = word_idx_q;
    stage_d       = stage_q;
    echo_d        = echo_q;
    miso_d        = miso_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    frame_cnt_d   = frame_cnt_q;
    ovr_set       = 1'b0;
    err_set       = 1'b0;

    if (cs) begin
      bit_cnt_d  = '0;
      word_idx_d = '0;
      echo_d     = '0;
      miso_d     = 1'b0;
      err_set    = (bit_cnt_q != '0) || (word_idx_q != '0);
    end else begin
      shift_d = word_asm;
      miso_d  = echo_q[miso_sel];
      if (word_done) begin
        stage_d[word_idx_q] = word_asm;
        echo_d              = word_asm;
        bit_cnt_d           = '0;
        word_idx_d          = (word_idx_q == IDX_LAST) ? '0 : word_idx_q + IDX_W'(1);
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
    end

    if (frame_done) begin
      if (!frame_valid_q || frame_ack) begin
        frame_data_d  = frame_full;
        frame_valid_d = 1'b1;
        frame_cnt_d   = frame_cnt_q + CNT_W'(1);
      end else begin
        ovr_set = 1'b1;
      end
    end else if (frame_ack && frame_valid_q) begin
      frame_valid_d = 1'b0;
    end

    // Setting a status bit takes priority over clearing it.
    overrun_d   = (clr_status ? 1'b0 : overrun_q) | ovr_set;
    frame_err_d = (clr_status ? 1'b0 : frame_err_q) | err_set;
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      word_idx_q    <= '0;
      for (int i = 0; i < NUM_WORDS; i++) stage_q[i] <= '0;
      echo_q        <= '0;
      miso_q        <= 1'b0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      word_idx_q    <= word_idx_d;
      stage_q       <= stage_d;
      echo_q        <= echo_d;
      miso_q        <= miso_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
      frame_err_q   <= frame_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign miso        = miso_q;
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign overrun     = overrun_q;
  assign frame_err   = frame_err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: default, MSB-first and narrow-counter instances,
// checked against a scoreboard of expected frames and a small status model.
module tb_spi_frame_rx;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic rst = 1'b1;

  // Instance A: defaults (16-bit words, 4 words, LSB-first)
  logic        cs_a = 1'b1, mosi_a = 1'b0, ack_a = 1'b0, clr_a = 1'b0;
  logic        miso_a, valid_a, ovr_a, err_a;
  logic [63:0] data_a;
  logic [7:0]  cnt_a;

  // Instance B: 8-bit words, 2 words, MSB-first
  logic        cs_b = 1'b1, mosi_b = 1'b0, ack_b = 1'b0, clr_b = 1'b0;
  logic        miso_b, valid_b, ovr_b, err_b;
  logic [15:0] data_b;
  logic [7:0]  cnt_b;

  // Instance C: 2-bit frame counter
  logic        cs_c = 1'b1, mosi_c = 1'b0, ack_c = 1'b0, clr_c = 1'b0;
  logic        miso_c, valid_c, ovr_c, err_c;
  logic [63:0] data_c;
  logic [1:0]  cnt_c;

  spi_frame_rx u_a (
    .sclk(sclk), .rst(rst), .cs(cs_a), .mosi(mosi_a), .miso(miso_a),
    .frame_ack(ack_a), .clr_status(clr_a), .frame_data(data_a),
    .frame_valid(valid_a), .overrun(ovr_a), .frame_err(err_a), .frame_cnt(cnt_a)
  );

  spi_frame_rx #(.WORD_W(8), .NUM_WORDS(2), .LSB_FIRST(0), .CNT_W(8)) u_b (
    .sclk(sclk), .rst(rst), .cs(cs_b), .mosi(mosi_b), .miso(miso_b),
    .frame_ack(ack_b), .clr_status(clr_b), .frame_data(data_b),
    .frame_valid(valid_b), .overrun(ovr_b), .frame_err(err_b), .frame_cnt(cnt_b)
  );

  spi_frame_rx #(.CNT_W(2)) u_c (
    .sclk(sclk), .rst(rst), .cs(cs_c), .mosi(mosi_c), .miso(miso_c),
    .frame_ack(ack_c), .clr_status(clr_c), .frame_data(data_c),
    .frame_valid(valid_c), .overrun(ovr_c), .frame_err(err_c), .frame_cnt(cnt_c)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model / scoreboard state
  logic        m_valid_a = 1'b0, m_ovr_a = 1'b0, m_err_a = 1'b0;
  logic [7:0]  m_cnt_a = 8'd0;
  logic [63:0] m_data_a = 64'd0;
  logic [63:0] exp_a [$];
  logic [15:0] miso_cap_a [4];
  logic [15:0] exp_b [$];
  logic [63:0] exp_c [$];
  logic [1:0]  m_cnt_c = 2'd0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic a_clk(input logic cs_v, input logic mosi_v, input logic ack_v, input logic clr_v);
    @(negedge sclk);
    cs_a = cs_v; mosi_a = mosi_v; ack_a = ack_v; clr_a = clr_v;
    @(posedge sclk); #1;
  endtask

  task automatic b_clk(input logic cs_v, input logic mosi_v);
    @(negedge sclk);
    cs_b = cs_v; mosi_b = mosi_v;
    @(posedge sclk); #1;
  endtask

  task automatic c_clk(input logic cs_v, input logic mosi_v, input logic ack_v);
    @(negedge sclk);
    cs_c = cs_v; mosi_c = mosi_v; ack_c = ack_v;
    @(posedge sclk); #1;
  endtask

  // Sends one full frame to instance A and checks the handshake outcome.
  task automatic a_frame(input logic [63:0] f, input logic ack_last, input string tag);
    logic accept;
    accept = !m_valid_a || ack_last;
    if (accept) begin
      exp_a.push_back(f);
      m_cnt_a = m_cnt_a + 8'd1;
    end else begin
      m_ovr_a = 1'b1;
    end
    m_valid_a = 1'b1;
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 16; b++) begin
        a_clk(1'b0, f[w*16+b], ack_last && (w == 3) && (b == 15), 1'b0);
        miso_cap_a[w][b] = miso_a;
      end
    end
    if (accept && exp_a.size() > 0) m_data_a = exp_a.pop_front();
    $display("frame %s: sent=%h ack=%0b data=%h valid=%0b cnt=%0d ovr=%0b err=%0b",
             tag, f, ack_last, data_a, valid_a, cnt_a, ovr_a, err_a);
    n_cmp++; if (valid_a !== m_valid_a) begin n_bad++; $display("FAIL %s valid: got %0b want %0b", tag, valid_a, m_valid_a); end
    n_cmp++; if (data_a !== m_data_a) begin n_bad++; $display("FAIL %s data: got %h want %h", tag, data_a, m_data_a); end
    n_cmp++; if (cnt_a !== m_cnt_a) begin n_bad++; $display("FAIL %s cnt: got %0d want %0d", tag, cnt_a, m_cnt_a); end
    n_cmp++; if (ovr_a !== m_ovr_a) begin n_bad++; $display("FAIL %s overrun: got %0b want %0b", tag, ovr_a, m_ovr_a); end
    n_cmp++; if (err_a !== m_err_a) begin n_bad++; $display("FAIL %s frame_err: got %0b want %0b", tag, err_a, m_err_a); end
  endtask

  task automatic a_ack(input string tag);
    a_clk(1'b1, 1'b0, 1'b1, 1'b0);
    m_valid_a = 1'b0;
    $display("ack %s: valid=%0b cnt=%0d", tag, valid_a, cnt_a);
    n_cmp++; if (valid_a !== m_valid_a) begin n_bad++; $display("FAIL %s ack valid: got %0b want %0b", tag, valid_a, m_valid_a); end
    n_cmp++; if (cnt_a !== m_cnt_a) begin n_bad++; $display("FAIL %s ack cnt: got %0d want %0d", tag, cnt_a, m_cnt_a); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge sclk);
    #1;
    $display("reset: A valid=%0b data=%h cnt=%0d miso=%0b", valid_a, data_a, cnt_a, miso_a);
    n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL reset valid_a: got %0b want 0", valid_a); end
    n_cmp++; if (data_a !== 64'd0) begin n_bad++; $display("FAIL reset data_a: got %h want 0", data_a); end
    n_cmp++; if (cnt_a !== 8'd0) begin n_bad++; $display("FAIL reset cnt_a: got %0d want 0", cnt_a); end
    n_cmp++; if ({miso_a, ovr_a, err_a} !== 3'b000) begin n_bad++; $display("FAIL reset status_a: got %b want 000", {miso_a, ovr_a, err_a}); end
    n_cmp++; if ({valid_b, valid_c, cnt_c} !== 4'd0) begin n_bad++; $display("FAIL reset b_c: got %b want 0000", {valid_b, valid_c, cnt_c}); end
    @(negedge sclk);
    rst = 1'b0;
  endtask

  task automatic test_lsb_frame();
    logic [63:0] f;
    f = 64'hFFFF_1234_8000_0001;
    a_frame(f, 1'b0, "lsb");
    for (int w = 0; w < 4; w++) begin
      logic [15:0] want;
      want = (w == 0) ? 16'd0 : f[(w-1)*16 +: 16];
      $display("miso A word %0d: got %h", w, miso_cap_a[w]);
      n_cmp++; if (miso_cap_a[w] !== want) begin n_bad++; $display("FAIL lsb miso word%0d: got %h want %h", w, miso_cap_a[w], want); end
    end
    a_ack("lsb");
    a_ack("idle");
  endtask

  task automatic test_msb_echo();
    logic [7:0] words [2];
    logic [7:0] cap [2];
    logic [15:0] want;
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    exp_b.push_back({words[1], words[0]});
    for (int w = 0; w < 2; w++) begin
      cap[w] = 8'd0;
      for (int i = 0; i < 8; i++) begin
        b_clk(1'b0, words[w][7-i]);
        cap[w] = {cap[w][6:0], miso_b};
      end
    end
    want = exp_b.pop_front();
    $display("frame msb: data=%h valid=%0b cnt=%0d miso0=%h miso1=%h", data_b, valid_b, cnt_b, cap[0], cap[1]);
    n_cmp++; if (valid_b !== 1'b1) begin n_bad++; $display("FAIL msb valid: got %0b want 1", valid_b); end
    n_cmp++; if (data_b !== want) begin n_bad++; $display("FAIL msb data: got %h want %h", data_b, want); end
    n_cmp++; if (cnt_b !== 8'd1) begin n_bad++; $display("FAIL msb cnt: got %0d want 1", cnt_b); end
    n_cmp++; if (cap[0] !== 8'h00) begin n_bad++; $display("FAIL msb miso word0: got %h want 00", cap[0]); end
    n_cmp++; if (cap[1] !== words[0]) begin n_bad++; $display("FAIL msb miso word1: got %h want %h", cap[1], words[0]); end
    b_clk(1'b1, 1'b0);
  endtask

  task automatic test_cs_resync();
    for (int i = 0; i < 20; i++) a_clk(1'b0, i[0], 1'b0, 1'b0);
    a_clk(1'b1, 1'b0, 1'b0, 1'b0);
    m_err_a = 1'b1;
    $display("resync: err=%0b valid=%0b", err_a, valid_a);
    n_cmp++; if (err_a !== m_err_a) begin n_bad++; $display("FAIL resync err: got %0b want %0b", err_a, m_err_a); end
    a_frame(64'h4444_3333_2222_1111, 1'b0, "resync");
    a_clk(1'b1, 1'b0, 1'b0, 1'b1);
    m_err_a = 1'b0;
    n_cmp++; if (err_a !== m_err_a) begin n_bad++; $display("FAIL clr err: got %0b want %0b", err_a, m_err_a); end
    // cs deasserted mid-word on the same edge as clr_status: set must win
    for (int i = 0; i < 5; i++) a_clk(1'b0, 1'b1, 1'b0, 1'b0);
    a_clk(1'b1, 1'b0, 1'b0, 1'b1);
    m_err_a = 1'b1;
    n_cmp++; if (err_a !== m_err_a) begin n_bad++; $display("FAIL set_wins err: got %0b want %0b", err_a, m_err_a); end
    a_clk(1'b1, 1'b0, 1'b0, 1'b1);
    m_err_a = 1'b0;
    n_cmp++; if (err_a !== m_err_a) begin n_bad++; $display("FAIL clr2 err: got %0b want %0b", err_a, m_err_a); end
    a_ack("resync");
  endtask

  task automatic test_back_to_back();
    a_frame(64'h0123_4567_89AB_CDEF, 1'b0, "b2b_first");
    a_frame(64'hDEAD_BEEF_CAFE_F00D, 1'b0, "b2b_dropped");
    a_frame(64'h5A5A_A5A5_0F0F_F0F0, 1'b1, "b2b_acked");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 40; i++) a_clk(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge sclk);
    rst = 1'b1;
    @(posedge sclk); #1;
    $display("reset_mid: valid=%0b data=%h cnt=%0d ovr=%0b err=%0b miso=%0b", valid_a, data_a, cnt_a, ovr_a, err_a, miso_a);
    n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid valid: got %0b want 0", valid_a); end
    n_cmp++; if (data_a !== 64'd0) begin n_bad++; $display("FAIL rst_mid data: got %h want 0", data_a); end
    n_cmp++; if (cnt_a !== 8'd0) begin n_bad++; $display("FAIL rst_mid cnt: got %0d want 0", cnt_a); end
    n_cmp++; if ({ovr_a, err_a, miso_a} !== 3'b000) begin n_bad++; $display("FAIL rst_mid status: got %b want 000", {ovr_a, err_a, miso_a}); end
    @(negedge sclk);
    rst = 1'b0;
    cs_a = 1'b1;
    m_valid_a = 1'b0; m_ovr_a = 1'b0; m_err_a = 1'b0; m_cnt_a = 8'd0; m_data_a = 64'd0;
    exp_a.delete();
    a_frame(64'h0F1E_2D3C_4B5A_6978, 1'b0, "after_rst");
  endtask

  task automatic test_cnt_wrap();
    for (int k = 0; k < 5; k++) begin
      logic [63:0] f;
      logic [63:0] want;
      f = {$urandom(), $urandom()};
      exp_c.push_back(f);
      m_cnt_c = m_cnt_c + 2'd1;
      for (int i = 0; i < 64; i++) c_clk(1'b0, f[i], 1'b0);
      want = exp_c.pop_front();
      $display("frame wrap%0d: sent=%h data=%h cnt=%0d", k, f, data_c, cnt_c);
      n_cmp++; if (data_c !== want) begin n_bad++; $display("FAIL wrap%0d data: got %h want %h", k, data_c, want); end
      n_cmp++; if (cnt_c !== m_cnt_c) begin n_bad++; $display("FAIL wrap%0d cnt: got %0d want %0d", k, cnt_c, m_cnt_c); end
      c_clk(1'b1, 1'b0, 1'b1);
      n_cmp++; if (valid_c !== 1'b0) begin n_bad++; $display("FAIL wrap%0d ack valid: got %0b want 0", k, valid_c); end
    end
  endtask

  initial begin
    test_reset();
    test_lsb_frame();
    test_msb_echo();
    test_cs_resync();
    test_back_to_back();
    test_cnt_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
